// File: rtl/sram_controller.sv
// 32-bit core data port to 16-bit asynchronous SRAM bridge: each access runs as two timed half-word cycles.
// Optional read-hit bypass of repeated loads is enabled by defining SRAM_READ_HIT_EN.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO_W,
      S_HI_W,
      S_LO_R,
      S_HI_R,
      S_DONE
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          phase_last;
   logic          hit;
   logic [16:0]   wa;
   logic [15:0]   dq_out;
   logic          dq_oe;

   assign wa         = 17'((address - ADDR_BASE) >> 2);
   assign phase_last = (cnt == LAST);
   assign SRAM_DQ    = dq_oe ? dq_out : 16'bz;

`ifdef SRAM_READ_HIT_EN
   logic [31:0] tag;
   logic        valid;

   // Tag remembers the last full read; any store invalidates it since it may alias.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag   <= '0;
         valid <= 1'b0;
      end else if (state == S_IDLE && state_next == S_LO_W) begin
         valid <= 1'b0;
      end else if (state == S_HI_R && phase_last) begin
         tag   <= address;
         valid <= 1'b1;
      end
   end

   assign hit = valid && (address == tag);
`else
   assign hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         state <= state_next;
         if (state_next != state || state == S_IDLE || state == S_DONE)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (state == S_LO_R && phase_last)
            rdata[15:0] <= SRAM_DQ;
         if (state == S_HI_R && phase_last)
            rdata[31:16] <= SRAM_DQ;
      end
   end

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      SRAM_ADDR  = '0;
      SRAM_UB_N  = 1'b1;
      SRAM_LB_N  = 1'b1;
      SRAM_WE_N  = 1'b1;
      SRAM_CE_N  = 1'b1;
      SRAM_OE_N  = 1'b1;
      dq_out     = '0;
      dq_oe      = 1'b0;

      case (state)
         S_IDLE: begin
            ready = ~(rd_en | wr_en);
            if (wr_en)
               state_next = S_LO_W;
            else if (rd_en)
               state_next = hit ? S_DONE : S_LO_R;
         end
         S_LO_W, S_HI_W: begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_WE_N = 1'b0;
            SRAM_ADDR = {wa, state == S_HI_W};
            dq_oe     = 1'b1;
            dq_out    = (state == S_HI_W) ? wdata[31:16] : wdata[15:0];
            if (phase_last)
               state_next = (state == S_LO_W) ? S_HI_W : S_DONE;
         end
         S_LO_R, S_HI_R: begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_OE_N = 1'b0;
            SRAM_ADDR = {wa, state == S_HI_R};
            if (phase_last)
               state_next = (state == S_LO_R) ? S_HI_R : S_DONE;
         end
         S_DONE: begin
            ready      = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: behavioural SRAM, per-cycle strobe checks, W=1 and W=3 instances.
module tb_sram_controller;

   localparam int W = 1;
   localparam int W3 = 3;
   localparam logic [15:0] KEEP = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] address = '0, wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;
   logic [4:0]  strobes;

   logic        rd3 = 1'b0;
   logic [31:0] addr3 = '0;
   logic [31:0] rdata3;
   logic        ready3;
   wire  [15:0] dq3;
   logic [17:0] sa3;
   logic        ub3, lb3, we3, ce3, oe3;

   logic [15:0] mem    [0:255];
   logic [15:0] shadow [0:255];
   logic [15:0] mem3   [0:255];
   logic [31:0] exp_q  [$];
   logic [31:0] last_rdata = '0;
   bit          tb_valid = 1'b0;
   logic [31:0] tb_tag = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
      .rdata(rdata), .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
   );

   sram_controller #(.WAIT_CYCLES(W3), .ADDR_BASE(32'd1024)) dut3 (
      .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd3), .address(addr3), .wdata(32'h0),
      .rdata(rdata3), .ready(ready3), .SRAM_DQ(dq3), .SRAM_ADDR(sa3),
      .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
   );

   assign strobes = {ce_n, ub_n, lb_n, we_n, oe_n};

   // Behavioural SRAM plus a keeper pattern that owns the bus whenever the chip is deselected.
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
   assign sram_dq = ce_n ? KEEP : 16'hzzzz;
   assign dq3     = (!ce3 && !oe3 && we3) ? mem3[sa3[7:0]] : 16'hzzzz;
   assign dq3     = ce3 ? KEEP : 16'hzzzz;

   always @(posedge clk)
      if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;

   task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input bit b2b, input string name);
      int          k;
      bit          hit, hi;
      logic [16:0] wa;
      logic [7:0]  lo_i, hi_i;
      logic [4:0]  exp_s;
      logic [15:0] exp_dq;
      logic [31:0] exp_rd;
      wa   = 17'((a - 32'd1024) >> 2);
      lo_i = {wa[6:0], 1'b0};
      hi_i = {wa[6:0], 1'b1};
      hit  = 1'b0;
`ifdef SRAM_READ_HIT_EN
      hit = !w && r && tb_valid && (tb_tag == a);
`endif
      if (!w) exp_q.push_back({shadow[hi_i], shadow[lo_i]});
      wr_en = w; rd_en = r; address = a; wdata = d;
      if (b2b) @(negedge clk);
      else #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL %s req_ready: got %b want 0", name, ready); end
      n_checks++;
      if (strobes !== 5'h1f) begin n_fail++; $display("FAIL %s req_strobes: got %b want 11111", name, strobes); end
      k = 0;
      forever begin
         @(negedge clk);
         k++;
         if (ready === 1'b1) break;
         if (k > 40) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: ready not seen after %0d cycles", name, k);
            break;
         end
         hi     = (k - 1) >= (W + 1);
         exp_s  = w ? 5'b00001 : 5'b00010;
         exp_dq = w ? (hi ? d[31:16] : d[15:0]) : (hi ? shadow[hi_i] : shadow[lo_i]);
         n_checks++;
         if (strobes !== exp_s) begin n_fail++; $display("FAIL %s strobes k=%0d: got %b want %b", name, k, strobes, exp_s); end
         n_checks++;
         if (sram_addr !== {wa, hi}) begin n_fail++; $display("FAIL %s addr k=%0d: got %0d want %0d", name, k, sram_addr, {wa, hi}); end
         n_checks++;
         if (sram_dq !== exp_dq) begin n_fail++; $display("FAIL %s dq k=%0d: got %h want %h", name, k, sram_dq, exp_dq); end
      end
      n_checks++;
      if (k !== (hit ? 1 : 2 * (W + 1) + 1)) begin
         n_fail++; $display("FAIL %s latency: got %0d want %0d", name, k, hit ? 1 : 2 * (W + 1) + 1);
      end
      n_checks++;
      if ({strobes, sram_addr, sram_dq} !== {5'h1f, 18'h0, KEEP}) begin
         n_fail++; $display("FAIL %s done_bus: got %b/%0d/%h want 11111/0/%h", name, strobes, sram_addr, sram_dq, KEEP);
      end
      if (!w) begin
         exp_rd = exp_q.pop_front();
         n_checks++;
         if (rdata !== exp_rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rd); end
         last_rdata = exp_rd;
         if (!hit) begin tb_valid = 1'b1; tb_tag = a; end
      end else begin
         n_checks++;
         if (rdata !== last_rdata) begin n_fail++; $display("FAIL %s rdata_hold: got %h want %h", name, rdata, last_rdata); end
         shadow[lo_i] = d[15:0];
         shadow[hi_i] = d[31:16];
         n_checks++;
         if ({mem[hi_i], mem[lo_i]} !== d) begin n_fail++; $display("FAIL %s sram_mem: got %h want %h", name, {mem[hi_i], mem[lo_i]}, d); end
         tb_valid = 1'b0;
      end
   endtask

   task automatic end_request(input string name);
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, ready); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      n_checks++;
      if ({strobes, sram_addr, sram_dq} !== {5'h1f, 18'h0, KEEP}) begin
         n_fail++; $display("FAIL reset_bus: got %b/%0d/%h want 11111/0/%h", strobes, sram_addr, sram_dq, KEEP);
      end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
      rst = 1'b1;
      last_rdata = '0;
      tb_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, "write");
      end_request("write");
   endtask

   task automatic test_read();
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "read");
      end_request("read");
   endtask

   task automatic test_both();
      run_access(1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b0, "both");
      end_request("both");
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, "b2b_rd0");
      run_access(1'b1, 1'b0, 32'd1044, 32'hCAFEF00D, 1'b1, "b2b_wr");
      run_access(1'b0, 1'b1, 32'd1044, 32'h0, 1'b1, "b2b_rd1");
      end_request("b2b");
   endtask

   task automatic test_read_hit();
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "hit_first");
      end_request("hit_first");
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "hit_second");
      end_request("hit_second");
      run_access(1'b1, 1'b0, 32'd1048, 32'h0BADF00D, 1'b0, "hit_store");
      end_request("hit_store");
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "hit_after_store");
      end_request("hit_after_store");
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; address = 32'd1100; wdata = 32'h11112222;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({strobes, sram_addr, sram_dq} !== {5'b00001, 18'd39, 16'h1111}) begin
         n_fail++; $display("FAIL rstmid_hi_w: got %b/%0d/%h want 00001/39/1111", strobes, sram_addr, sram_dq);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({strobes, sram_addr, sram_dq} !== {5'h1f, 18'h0, KEEP}) begin
         n_fail++; $display("FAIL rstmid_abort: got %b/%0d/%h want 11111/0/%h", strobes, sram_addr, sram_dq, KEEP);
      end
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      last_rdata = '0;
      tb_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready, strobes, rdata} !== {1'b1, 5'h1f, 32'h0}) begin
         n_fail++; $display("FAIL rstmid_idle: got %b/%b/%h want 1/11111/0", ready, strobes, rdata);
      end
      run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "rstmid_read");
      end_request("rstmid_read");
   endtask

   task automatic test_wait3();
      int          k;
      int          oe_cnt;
      logic [31:0] exp_rd;
      exp_q.push_back({mem3[5], mem3[4]});
      rd3 = 1'b1; addr3 = 32'd1032;
      k = 0; oe_cnt = 0;
      forever begin
         @(negedge clk);
         k++;
         if (ready3 === 1'b1) break;
         if (k > 40) begin
            n_checks++; n_fail++;
            $display("FAIL w3 timeout: ready not seen after %0d cycles", k);
            break;
         end
         if (!oe3 && !ce3) oe_cnt++;
      end
      n_checks++;
      if (k !== 2 * (W3 + 1) + 1) begin n_fail++; $display("FAIL w3_latency: got %0d want %0d", k, 2 * (W3 + 1) + 1); end
      n_checks++;
      if (oe_cnt !== 2 * (W3 + 1)) begin n_fail++; $display("FAIL w3_oe_cycles: got %0d want %0d", oe_cnt, 2 * (W3 + 1)); end
      exp_rd = exp_q.pop_front();
      n_checks++;
      if (rdata3 !== exp_rd) begin n_fail++; $display("FAIL w3_rdata: got %h want %h", rdata3, exp_rd); end
      rd3 = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready3, ce3, dq3} !== {1'b1, 1'b1, KEEP}) begin
         n_fail++; $display("FAIL w3_idle: got %b/%b/%h want 1/1/%h", ready3, ce3, dq3, KEEP);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 16'h0;
         shadow[i] = 16'h0;
         mem3[i]   = 16'h0;
      end
      mem3[4] = 16'h5678;
      mem3[5] = 16'h1234;
      test_reset();
      test_write();
      test_read();
      test_both();
      test_back_to_back();
      test_read_hit();
      test_reset_mid();
      test_wait3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
